// File: rtl/rc5_pkg.sv
// Shared definitions for the RC5 receiver control block: CSR register indices,
// CTRL bit positions and the bit layout of a decoded 13-bit frame.
package rc5_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_DROPS  = 2'd3;

    localparam int CTRL_ENABLE    = 0;
    localparam int CTRL_FILTER_EN = 1;
    localparam int CTRL_DROP_REP  = 2;
    localparam int CTRL_IRQ_EN    = 3;
    localparam int CTRL_FADDR_LSB = 8;
    localparam int CTRL_FADDR_MSB = 12;
    localparam logic [12:0] CTRL_MASK = 13'h1F0F;

    localparam int STATUS_OVF_CLR = 2;

    localparam int FRAME_W    = 13;
    localparam int FIELD_BIT  = 12;
    localparam int TOGGLE_BIT = 11;
    localparam int ADDR_MSB   = 10;
    localparam int ADDR_LSB   = 6;
    localparam int CMD_MSB    = 5;
    localparam int CMD_LSB    = 0;

    // Everything below the field bit identifies a keypress for repeat detection.
    localparam int CODE_W = FIELD_BIT;

endpackage

// File: rtl/rc5_fifo.sv
// Small synchronous FIFO holding accepted RC5 frames until software reads them.
// The caller guarantees push is only raised when space exists (or a pop frees it).
module rc5_fifo
    import rc5_pkg::*;
#(
    parameter int depth_log2 = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [FRAME_W-1:0]     din,
    output logic [FRAME_W-1:0]     head,
    output logic                   full,
    output logic                   empty,
    output logic [depth_log2:0]    level
);

    localparam int DEPTH = 2 ** depth_log2;
    localparam logic [depth_log2-1:0] PTR_ONE = 1;
    localparam logic [depth_log2:0]   LVL_ONE = 1;
    localparam logic [depth_log2:0]   LVL_FULL = DEPTH;

    logic [FRAME_W-1:0]    mem_q [DEPTH];
    logic [FRAME_W-1:0]    mem_d [DEPTH];
    logic [depth_log2-1:0] wptr_q, wptr_d;
    logic [depth_log2-1:0] rptr_q, rptr_d;
    logic [depth_log2:0]   level_q, level_d;

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (push) begin
            mem_d[wptr_q] = din;
            wptr_d        = wptr_q + PTR_ONE;
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    assign head  = mem_q[rptr_q];
    assign full  = (level_q == LVL_FULL);
    assign empty = (level_q == '0);
    assign level = level_q;

endmodule

// File: rtl/rc5_ctrl.sv
// Control/buffer block between the RC5 receiver core and the CSR bus: enables the
// receiver, filters and de-repeats decoded frames, queues them and raises irq.
module rc5_ctrl
    import rc5_pkg::*;
#(
    parameter logic [3:0] csr_addr   = 4'h0,
    parameter int          depth_log2 = 2,
    parameter int          clk_freq   = 100000000,
    parameter int          repeat_ms  = 150
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [13:0]        csr_a,
    input  logic               csr_we,
    input  logic [31:0]        csr_di,
    output logic [31:0]        csr_do,
    output logic               irq,
    input  logic               frame_stb,
    input  logic [FRAME_W-1:0] frame_data,
    output logic               rx_enable
);

    localparam int LW = depth_log2 + 1;
    localparam logic [31:0] WINDOW_CYCLES = 32'(clk_freq / 1000 * repeat_ms);

    logic [12:0]       ctrl_q, ctrl_d;
    logic [31:0]       csr_do_q, csr_do_d;
    logic              irq_q, irq_d;
    logic              ovf_q, ovf_d;
    logic [15:0]       drops_q, drops_d;
    logic [CODE_W-1:0] last_q, last_d;
    logic              last_valid_q, last_valid_d;
    logic [31:0]       win_q, win_d;

    logic [FRAME_W-1:0] fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [LW-1:0]      fifo_level;
    logic               fifo_push;
    logic               fifo_pop;

    logic        csr_sel, csr_rd, csr_wr;
    logic [1:0]  reg_idx;
    logic        ctrl_wr, status_wr, drops_wr, disabling;
    logic        enable, filter_en, drop_rep, irq_en;
    logic [4:0]  filter_addr;
    logic        stb_live, addr_ok, is_repeat, accept, rep_hit, ovf_hit;
    logic [31:0] rdata;
    logic        unused_bits;

    assign unused_bits = ^{csr_a[9:2], csr_di[31:13]};

    // A selected read lasts exactly one cycle; its data is registered into csr_do
    // on the following edge, and a DATA read pops the FIFO on that same edge.
    always_comb begin
        csr_sel   = (csr_a[13:10] == csr_addr);
        reg_idx   = csr_a[1:0];
        csr_rd    = csr_sel & ~csr_we;
        csr_wr    = csr_sel & csr_we;
        ctrl_wr   = csr_wr & (reg_idx == REG_CTRL);
        status_wr = csr_wr & (reg_idx == REG_STATUS);
        drops_wr  = csr_wr & (reg_idx == REG_DROPS);
        disabling = ctrl_wr & ~csr_di[CTRL_ENABLE];

        enable      = ctrl_q[CTRL_ENABLE];
        filter_en   = ctrl_q[CTRL_FILTER_EN];
        drop_rep    = ctrl_q[CTRL_DROP_REP];
        irq_en      = ctrl_q[CTRL_IRQ_EN];
        filter_addr = ctrl_q[CTRL_FADDR_MSB:CTRL_FADDR_LSB];

        stb_live  = frame_stb & enable;
        addr_ok   = ~filter_en | (frame_data[ADDR_MSB:ADDR_LSB] == filter_addr);
        is_repeat = drop_rep & last_valid_q & (win_q != '0)
                  & (frame_data[CODE_W-1:0] == last_q);
        accept    = stb_live & addr_ok & ~is_repeat;
        rep_hit   = stb_live & addr_ok & is_repeat;

        fifo_pop  = csr_rd & (reg_idx == REG_DATA) & ~fifo_empty;
        fifo_push = accept & (~fifo_full | fifo_pop);
        ovf_hit   = accept & fifo_full & ~fifo_pop;
    end

    always_comb begin
        ctrl_d = ctrl_q;
        if (ctrl_wr) begin
            ctrl_d = csr_di[12:0] & CTRL_MASK;
        end

        last_d = last_q;
        if (accept) begin
            last_d = frame_data[CODE_W-1:0];
        end

        last_valid_d = last_valid_q;
        if (accept) begin
            last_valid_d = 1'b1;
        end
        if (disabling) begin
            last_valid_d = 1'b0;
        end

        win_d = win_q;
        if (win_q != '0) begin
            win_d = win_q - 32'd1;
        end
        if (accept | rep_hit) begin
            win_d = WINDOW_CYCLES;
        end
        if (disabling) begin
            win_d = '0;
        end

        // A same-cycle overflow beats a software clear so no loss goes unreported.
        ovf_d = ovf_q;
        if (status_wr & csr_di[STATUS_OVF_CLR]) begin
            ovf_d = 1'b0;
        end
        if (ovf_hit) begin
            ovf_d = 1'b1;
        end

        drops_d = drops_q;
        if (ovf_hit && drops_q != 16'hFFFF) begin
            drops_d = drops_q + 16'd1;
        end
        if (drops_wr) begin
            drops_d = '0;
        end

        irq_d = irq_en & ~fifo_empty;
    end

    always_comb begin
        rdata = '0;
        case (reg_idx)
            REG_CTRL:   rdata = {19'd0, ctrl_q};
            REG_STATUS: rdata = {24'd0, 4'(fifo_level), 1'b0, ovf_q, fifo_full, ~fifo_empty};
            REG_DATA:   rdata = fifo_empty ? 32'd0 : {19'd0, fifo_head};
            REG_DROPS:  rdata = {16'd0, drops_q};
            default:    rdata = '0;
        endcase
        csr_do_d = csr_sel ? rdata : 32'd0;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ctrl_q       <= '0;
            csr_do_q     <= '0;
            irq_q        <= 1'b0;
            ovf_q        <= 1'b0;
            drops_q      <= '0;
            last_q       <= '0;
            last_valid_q <= 1'b0;
            win_q        <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            csr_do_q     <= csr_do_d;
            irq_q        <= irq_d;
            ovf_q        <= ovf_d;
            drops_q      <= drops_d;
            last_q       <= last_d;
            last_valid_q <= last_valid_d;
            win_q        <= win_d;
        end
    end

    rc5_fifo #(
        .depth_log2(depth_log2)
    ) u_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (frame_data),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign csr_do    = csr_do_q;
    assign irq       = irq_q;
    assign rx_enable = ctrl_q[CTRL_ENABLE];

endmodule

// File: tb/tb_rc5_ctrl.sv
// Directed bench for rc5_ctrl: CSR reads push expected data into a queue that a
// monitor drains as registered read data appears; side outputs are checked inline.
module tb_rc5_ctrl;

    localparam logic [13:0] IDLE_ADDR = 14'h3C00;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [13:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_di;
    logic [31:0] csr_do;
    logic        irq;
    logic        frame_stb;
    logic [12:0] frame_data;
    logic        rx_enable;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        rd_flag = 1'b0;
    logic        mon_pend;

    always #5 sys_clk = ~sys_clk;

    rc5_ctrl #(
        .csr_addr   (4'h0),
        .depth_log2 (2),
        .clk_freq   (1000),
        .repeat_ms  (100)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .csr_a      (csr_a),
        .csr_we     (csr_we),
        .csr_di     (csr_di),
        .csr_do     (csr_do),
        .irq        (irq),
        .frame_stb  (frame_stb),
        .frame_data (frame_data),
        .rx_enable  (rx_enable)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: a read presented in a cycle is answered on csr_do after that edge.
    initial begin
        forever begin
            @(posedge sys_clk);
            mon_pend = rd_flag;
            @(negedge sys_clk);
            if (mon_pend) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_read: got 0x%08h, expected nothing queued", csr_do);
                end else begin
                    check(name_q.pop_front(), csr_do, exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic csr_write(input logic [1:0] idx, input logic [31:0] d);
        csr_a  = {4'h0, 8'h00, idx};
        csr_we = 1'b1;
        csr_di = d;
        tick(1);
        csr_we = 1'b0;
        csr_a  = IDLE_ADDR;
        csr_di = '0;
    endtask

    task automatic csr_read(input logic [1:0] idx, input logic [31:0] exp, input string nm);
        csr_a   = {4'h0, 8'h00, idx};
        csr_we  = 1'b0;
        rd_flag = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        tick(1);
        rd_flag = 1'b0;
        csr_a   = IDLE_ADDR;
    endtask

    task automatic strobe(input logic [12:0] d);
        frame_stb  = 1'b1;
        frame_data = d;
        tick(1);
        frame_stb  = 1'b0;
    endtask

    task automatic read_data_with_strobe(input logic [31:0] exp, input string nm,
                                         input logic [12:0] d);
        csr_a      = {4'h0, 8'h00, 2'd2};
        csr_we     = 1'b0;
        rd_flag    = 1'b1;
        frame_stb  = 1'b1;
        frame_data = d;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        tick(1);
        rd_flag   = 1'b0;
        frame_stb = 1'b0;
        csr_a     = IDLE_ADDR;
    endtask

    initial begin
        sys_rst_n  = 1'b0;
        csr_a      = IDLE_ADDR;
        csr_we     = 1'b0;
        csr_di     = '0;
        frame_stb  = 1'b0;
        frame_data = '0;
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;

        // 1: reset state
        check("rst_csr_do", csr_do, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'h0);
        check("rst_rx_enable", {31'd0, rx_enable}, 32'h0);
        csr_read(2'd1, 32'h0, "rst_status");
        csr_read(2'd0, 32'h0, "rst_ctrl");
        csr_read(2'd2, 32'h0, "rst_data");

        // 2: enable + irq_en, single frame, irq latency and pop
        csr_write(2'd0, 32'h9);
        check("t2_rx_enable", {31'd0, rx_enable}, 32'h1);
        csr_read(2'd0, 32'h9, "t2_ctrl");
        strobe(13'h1A3C);
        check("t2_irq_1cyc", {31'd0, irq}, 32'h0);
        tick(1);
        check("t2_irq_2cyc", {31'd0, irq}, 32'h1);
        csr_read(2'd2, 32'h1A3C, "t2_data");
        tick(1);
        check("t2_irq_after_pop", {31'd0, irq}, 32'h0);
        csr_read(2'd1, 32'h0, "t2_status");
        csr_read(2'd2, 32'h0, "t2_data_empty");
        csr_read(2'd1, 32'h0, "t2_status_no_underflow");

        // 3: address filter on address 5
        csr_write(2'd0, 32'h503);
        csr_read(2'd0, 32'h503, "t3_ctrl");
        strobe(13'h0152);
        strobe(13'h01D2);
        tick(1);
        csr_read(2'd1, 32'h11, "t3_status");
        csr_read(2'd2, 32'h152, "t3_data");
        csr_read(2'd1, 32'h0, "t3_status_drained");

        // 4: repeat suppression with a 100-cycle window
        csr_write(2'd0, 32'h5);
        strobe(13'h0845);
        tick(19);
        strobe(13'h0845);
        tick(19);
        strobe(13'h0845);
        csr_read(2'd1, 32'h11, "t4_status_one");
        tick(199);
        strobe(13'h0845);
        strobe(13'h0C45);
        csr_read(2'd1, 32'h31, "t4_status_three");
        csr_read(2'd2, 32'h0845, "t4_data0");
        csr_read(2'd2, 32'h0845, "t4_data1");
        csr_read(2'd2, 32'h0C45, "t4_data2");
        csr_read(2'd3, 32'h0, "t4_drops");

        // 5: overflow
        csr_write(2'd0, 32'h1);
        strobe(13'h0101);
        strobe(13'h0202);
        strobe(13'h0303);
        strobe(13'h0404);
        strobe(13'h0505);
        csr_read(2'd1, 32'h47, "t5_status_full_ovf");
        csr_read(2'd3, 32'h1, "t5_drops");
        csr_read(2'd2, 32'h0101, "t5_data0");
        csr_read(2'd2, 32'h0202, "t5_data1");
        csr_read(2'd2, 32'h0303, "t5_data2");
        csr_read(2'd2, 32'h0404, "t5_data3");
        csr_read(2'd1, 32'h04, "t5_status_ovf_only");
        csr_write(2'd1, 32'h4);
        csr_read(2'd1, 32'h0, "t5_status_cleared");
        csr_write(2'd3, 32'h0);
        csr_read(2'd3, 32'h0, "t5_drops_cleared");

        // 6: push and pop in the same cycle while full
        strobe(13'h0A01);
        strobe(13'h0A02);
        strobe(13'h0A03);
        strobe(13'h0A04);
        csr_read(2'd1, 32'h43, "t6_status_full");
        read_data_with_strobe(32'h0A01, "t6_data_pushpop", 13'h0A05);
        csr_read(2'd1, 32'h43, "t6_status_still_full");
        csr_read(2'd3, 32'h0, "t6_drops");
        csr_read(2'd2, 32'h0A02, "t6_data1");
        csr_read(2'd2, 32'h0A03, "t6_data2");
        csr_read(2'd2, 32'h0A04, "t6_data3");
        csr_read(2'd2, 32'h0A05, "t6_data4");
        csr_read(2'd1, 32'h0, "t6_status_empty");

        // asynchronous reset in the middle of a cycle with a frame on the wire
        csr_write(2'd0, 32'h9);
        strobe(13'h1FFF);
        tick(1);
        check("t6_irq_before_rst", {31'd0, irq}, 32'h1);
        csr_read(2'd1, 32'h11, "t6_status_before_rst");
        @(negedge sys_clk);
        #2;
        frame_stb  = 1'b1;
        frame_data = 13'h0123;
        sys_rst_n  = 1'b0;
        #1;
        check("async_rst_csr_do", csr_do, 32'h0);
        check("async_rst_irq", {31'd0, irq}, 32'h0);
        check("async_rst_rx_enable", {31'd0, rx_enable}, 32'h0);
        frame_stb = 1'b0;
        tick(2);
        sys_rst_n = 1'b1;
        csr_read(2'd1, 32'h0, "post_rst_status");
        csr_read(2'd0, 32'h0, "post_rst_ctrl");
        csr_read(2'd2, 32'h0, "post_rst_data");

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            tick(1);
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: %0d reads unanswered, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
